// File: rtl/decode_stage.sv
// Decode and operand-read stage feeding the RV32I integer ALU.
// Owns x0..x31, a per-register busy scoreboard, and the registered decode bundle.
module decode_stage #(
    parameter int DATA_WIDTH = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clk_en,
    input  logic                  i_instr_valid,
    output logic                  o_instr_ready,
    input  logic [31:0]           i_instr,
    input  logic                  i_wb_en,
    input  logic [4:0]            i_wb_addr,
    input  logic [DATA_WIDTH:0]   i_wb_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [6:0]            o_opcode,
    output logic [6:0]            o_funct7,
    output logic [2:0]            o_funct3,
    output logic [DATA_WIDTH:0]   o_rs1_data,
    output logic [DATA_WIDTH:0]   o_rs2_data,
    output logic [31:0]           o_imm,
    output logic [4:0]            o_rd_addr,
    output logic                  o_rd_we,
    output logic                  o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'h00;
    localparam logic [6:0] F7_ALT     = 7'h20;

    logic [DATA_WIDTH:0] regs [32];
    logic [31:0]         busy;
    logic [4:0]          held_rs1;
    logic [4:0]          held_rs2;

    logic [6:0]          opcode;
    logic [6:0]          funct7;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [4:0]          rd;
    logic                is_op;
    logic                is_op_imm;
    logic                legal;
    logic                rd_we;
    logic [31:0]         imm;
    logic                wb_write;
    logic [31:0]         wb_clear;
    logic [31:0]         rd_set;
    logic [31:0]         busy_eff;
    logic                hazard;
    logic                accept;
    logic [DATA_WIDTH:0] rs1_data;
    logic [DATA_WIDTH:0] rs2_data;

    assign opcode    = i_instr[6:0];
    assign rd        = i_instr[11:7];
    assign funct3    = i_instr[14:12];
    assign rs1       = i_instr[19:15];
    assign rs2       = i_instr[24:20];
    assign funct7    = i_instr[31:25];
    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);

    always_comb begin
        legal = 1'b0;
        if (is_op) begin
            legal = (funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (is_op_imm) begin
            case (funct3)
                3'b001:  legal = (funct7 == F7_ZERO);
                3'b101:  legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                default: legal = 1'b1;
            endcase
        end
    end

    assign imm   = (is_op_imm && legal) ? {{20{i_instr[31]}}, i_instr[31:20]} : 32'd0;
    assign rd_we = legal && (rd != 5'd0);

    assign wb_write = i_wb_en && (i_wb_addr != 5'd0);
    assign wb_clear = i_wb_en ? (32'd1 << i_wb_addr) : 32'd0;
    assign rd_set   = (accept && rd_we) ? (32'd1 << rd) : 32'd0;

    // A writeback retiring a busy register this cycle releases the stall immediately.
    assign busy_eff = busy & ~wb_clear;
    assign hazard   = ((is_op || is_op_imm) && busy_eff[rs1]) || (is_op && busy_eff[rs2]);

    assign o_instr_ready = clk_en && (!o_valid || i_ready) && !hazard;
    assign accept        = i_instr_valid && o_instr_ready;

    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
        if (wb_write && (i_wb_addr == rs1)) begin
            rs1_data = i_wb_data;
        end
        if (wb_write && (i_wb_addr == rs2)) begin
            rs2_data = i_wb_data;
        end
        if (rs1 == 5'd0) begin
            rs1_data = '0;
        end
        if (rs2 == 5'd0) begin
            rs2_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (clk_en && wb_write) begin
            regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Ordering of clear-then-set makes a same-cycle set win over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 32'd0;
        end else if (clk_en) begin
            busy <= ((busy & ~wb_clear) | rd_set) & ~32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_valid    <= 1'b0;
            o_opcode   <= 7'd0;
            o_funct7   <= 7'd0;
            o_funct3   <= 3'd0;
            o_rs1_data <= '0;
            o_rs2_data <= '0;
            o_imm      <= 32'd0;
            o_rd_addr  <= 5'd0;
            o_rd_we    <= 1'b0;
            o_illegal  <= 1'b0;
            held_rs1   <= 5'd0;
            held_rs2   <= 5'd0;
        end else if (clk_en) begin
            if (accept) begin
                o_valid    <= 1'b1;
                o_opcode   <= opcode;
                o_funct7   <= funct7;
                o_funct3   <= funct3;
                o_rs1_data <= rs1_data;
                o_rs2_data <= rs2_data;
                o_imm      <= imm;
                o_rd_addr  <= rd;
                o_rd_we    <= rd_we;
                o_illegal  <= !legal;
                held_rs1   <= rs1;
                held_rs2   <= rs2;
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end else if (o_valid && wb_write) begin
                // A stalled bundle keeps tracking writebacks to its source registers.
                if (i_wb_addr == held_rs1) begin
                    o_rs1_data <= i_wb_data;
                end
                if (i_wb_addr == held_rs2) begin
                    o_rs2_data <= i_wb_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a spec-level model predicts every bundle
// and the ready/valid behaviour, directed scenarios followed by random traffic.
module tb_decode_stage;

    localparam int DW = 31;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clk_en = 1'b0;
    logic          i_instr_valid = 1'b0;
    logic          o_instr_ready;
    logic [31:0]   i_instr = 32'd0;
    logic          i_wb_en = 1'b0;
    logic [4:0]    i_wb_addr = 5'd0;
    logic [DW:0]   i_wb_data = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [6:0]    o_opcode;
    logic [6:0]    o_funct7;
    logic [2:0]    o_funct3;
    logic [DW:0]   o_rs1_data;
    logic [DW:0]   o_rs2_data;
    logic [31:0]   o_imm;
    logic [4:0]    o_rd_addr;
    logic          o_rd_we;
    logic          o_illegal;

    decode_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr(i_instr),
        .i_wb_en(i_wb_en), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm(o_imm),
        .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opcode;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        rd_we;
        logic        illegal;
    } exp_t;

    exp_t        exp_q[$];
    logic [DW:0] mregs [32];
    bit          mbusy [32];
    bit          mvalid;
    int          tests = 0;
    int          fails = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural meaning of an instruction word, independent of any datapath.
    function automatic exp_t decode(input logic [31:0] w);
        exp_t e;
        bit   legal;
        int   v;
        e.opcode = w[6:0];
        e.funct7 = w[31:25];
        e.funct3 = w[14:12];
        e.rd     = w[11:7];
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        if (e.opcode == 7'h33)
            legal = (e.funct7 == 7'h00) || (e.funct7 == 7'h20 && (e.funct3 == 3'd0 || e.funct3 == 3'd5));
        else if (e.opcode == 7'h13)
            legal = (e.funct3 == 3'd1) ? (e.funct7 == 7'h00) :
                    (e.funct3 == 3'd5) ? (e.funct7 == 7'h00 || e.funct7 == 7'h20) : 1'b1;
        else
            legal = 1'b0;
        v = int'(w[31:20]);
        if (v >= 2048) v = v - 4096;
        e.imm     = (legal && e.opcode == 7'h13) ? 32'(v) : 32'd0;
        e.illegal = !legal;
        e.rd_we   = legal && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic bit model_hazard(input logic [31:0] w, input logic wb_en, input logic [4:0] wb_addr);
        bit b1;
        bit b2;
        b1 = mbusy[w[19:15]] && !(wb_en && wb_addr == w[19:15]);
        b2 = mbusy[w[24:20]] && !(wb_en && wb_addr == w[24:20]);
        if (w[6:0] == 7'h13) return b1;
        if (w[6:0] == 7'h33) return b1 || b2;
        return 1'b0;
    endfunction

    function automatic logic [31:0] enc_i(input int f3, input int rd, input int rs1, input int imm12);
        return {12'(imm12), 5'(rs1), 3'(f3), 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction

    // Predictor: just before each edge, decide what that edge does to the model.
    initial begin : predictor
        bit   acc;
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                exp_q.delete();
                mvalid = 1'b0;
                for (int i = 0; i < 32; i++) begin
                    mbusy[i] = 1'b0;
                    mregs[i] = '0;
                end
            end else if (clk_en) begin
                acc = i_instr_valid && (!mvalid || i_ready) && !model_hazard(i_instr, i_wb_en, i_wb_addr);
                e   = decode(i_instr);
                if (i_wb_en) mbusy[i_wb_addr] = 1'b0;
                if (i_wb_en && i_wb_addr != 5'd0) mregs[i_wb_addr] = i_wb_data;
                if (acc) begin
                    exp_q.push_back(e);
                    mvalid = 1'b1;
                    if (e.rd_we) mbusy[e.rd] = 1'b1;
                end else if (i_ready) begin
                    mvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: operands are checked when consumed, against architectural register state.
    initial begin : monitor
        exp_t e;
        bit   exp_ready;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_ready = clk_en && (!mvalid || i_ready) && !model_hazard(i_instr, i_wb_en, i_wb_addr);
                check_output("instr_ready", 64'(o_instr_ready), 64'(exp_ready));
                check_output("valid", 64'(o_valid), 64'(mvalid));
                if (clk_en && mvalid && i_ready) begin
                    if (exp_q.size() == 0) begin
                        check_output("bundle_queue", 64'(0), 64'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check_output("opcode", 64'(o_opcode), 64'(e.opcode));
                        check_output("funct7", 64'(o_funct7), 64'(e.funct7));
                        check_output("funct3", 64'(o_funct3), 64'(e.funct3));
                        check_output("imm", 64'(o_imm), 64'(e.imm));
                        check_output("rd_addr", 64'(o_rd_addr), 64'(e.rd));
                        check_output("rd_we", 64'(o_rd_we), 64'(e.rd_we));
                        check_output("illegal", 64'(o_illegal), 64'(e.illegal));
                        check_output("rs1_data", 64'(o_rs1_data), 64'(mregs[e.rs1]));
                        check_output("rs2_data", 64'(o_rs2_data), 64'(mregs[e.rs2]));
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input bit valid, input logic [31:0] instr, input bit wb_en,
                                  input logic [4:0] wb_addr, input logic [31:0] wb_data,
                                  input bit ready, input bit en);
        @(posedge clk);
        #1;
        i_instr_valid = valid;
        i_instr       = instr;
        i_wb_en       = wb_en;
        i_wb_addr     = wb_addr;
        i_wb_data     = wb_data;
        i_ready       = ready;
        clk_en        = en;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_valid"}, 64'(o_valid), 64'(0));
        check_output({tag, "_rs1"}, 64'(o_rs1_data), 64'(0));
        check_output({tag, "_rs2"}, 64'(o_rs2_data), 64'(0));
        check_output({tag, "_imm"}, 64'(o_imm), 64'(0));
        check_output({tag, "_rd"}, 64'(o_rd_addr), 64'(0));
        check_output({tag, "_opcode"}, 64'(o_opcode), 64'(0));
    endtask

    function automatic logic [31:0] random_instr();
        int kind;
        int f7;
        kind = $urandom_range(0, 9);
        case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h00;
            default: f7 = $urandom_range(0, 127);
        endcase
        if (kind <= 4)
            return enc_i($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         (f7 << 5) | $urandom_range(0, 31));
        if (kind <= 8)
            return enc_r(f7, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7));
        return $urandom;
    endfunction

    function automatic logic [4:0] pick_wb_addr();
        int cand[$];
        for (int i = 1; i < 32; i++) begin
            if (mbusy[i]) cand.push_back(i);
        end
        if (cand.size() != 0 && $urandom_range(0, 1) == 1)
            return 5'(cand[$urandom_range(0, cand.size() - 1)]);
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin : driver
        #1 rst = 1'b0;
        #1 check_reset_state("reset");
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        rst = 1'b1;

        // Forward a writeback into a dependent ADDI, then stall on its result.
        apply_stimulus(0, 0, 1, 5, 32'h11, 1, 1);
        apply_stimulus(1, 32'hFFF28313, 0, 0, 0, 1, 1);
        apply_stimulus(1, enc_r(0, 0, 7, 6, 6), 0, 0, 0, 1, 1);
        apply_stimulus(1, enc_r(0, 0, 7, 6, 6), 1, 6, 32'h10, 1, 1);
        apply_stimulus(1, 32'h40315093, 0, 0, 0, 1, 1);
        apply_stimulus(1, enc_r(7'h20, 1, 3, 1, 2), 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);

        // Held bundle picks up a writeback to its source.
        apply_stimulus(1, enc_i(0, 10, 9, 0), 0, 0, 0, 0, 1);
        apply_stimulus(1, enc_i(0, 11, 2, 5), 1, 9, 32'hAA, 0, 1);
        apply_stimulus(1, enc_i(0, 11, 2, 5), 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);

        // x0 ignores writes and never becomes busy.
        apply_stimulus(0, 0, 1, 0, 32'h55, 1, 1);
        apply_stimulus(1, enc_i(0, 0, 0, 1), 0, 0, 0, 1, 1);
        apply_stimulus(1, enc_r(0, 0, 3, 0, 0), 0, 0, 0, 1, 1);

        // Disabled clock enable freezes everything, including writebacks.
        apply_stimulus(1, enc_i(0, 4, 3, 0), 1, 3, 32'h77, 1, 0);
        apply_stimulus(1, enc_i(0, 4, 3, 0), 1, 3, 32'h77, 1, 0);
        apply_stimulus(1, enc_i(0, 4, 3, 0), 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);

        // Reset in the middle of a stall.
        apply_stimulus(1, enc_i(0, 12, 9, 0), 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_state("midreset");
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        rst = 1'b1;
        apply_stimulus(1, enc_i(0, 13, 9, 0), 0, 0, 0, 1, 1);
        apply_stimulus(1, enc_r(0, 0, 14, 10, 6), 0, 0, 0, 1, 1);

        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 3) != 0, random_instr(), $urandom_range(0, 2) == 0,
                           pick_wb_addr(), $urandom, $urandom_range(0, 3) != 0,
                           $urandom_range(0, 9) != 0);
        end

        for (int n = 0; n < 10; n++) begin
            apply_stimulus(0, 0, 0, 0, 0, 1, 1);
        end
        @(negedge clk);
        check_output("drained", 64'(exp_q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
